// File: rtl/fir_ram_data_buf.sv
// ---------------------------------------------------------------------------
// fir_ram_data_buf
//
// Sample delay line for the parallel FIR datapath. Holds the last FILTER_ORDER
// samples in PARALLEL banks of ITERATION words each. Every accepted sample
// fires a one-cycle start pulse to the compute core, which then pulls
// ITERATION vectors of PARALLEL past samples, one per read strobe. Lane i of
// step k carries x[n - (i*ITERATION + k)], matching the core's coefficient
// addressing.
//
// Optional feature (macro FIR_RAM_DBUF_CLEAR_EN): after reset all banks are
// zero-filled (one address per cycle, all banks in parallel) before the first
// sample is accepted, so early outputs reflect an all-zero history. Without
// the macro the zero-fill is skipped and the buffer is ready right after reset.
//
// Ports:
//   clk_i          clock
//   rst_n_i        synchronous active-low reset
//   sample_i       signed input sample
//   sample_val_i   sample valid
//   sample_rdy_o   buffer can accept a sample (high only while idle)
//   data_val_o     one-cycle start pulse to the compute core
//   data_ram_rd_i  core read strobe, one vector per high cycle (2-cycle latency)
//   data_ram_o     read vector, lane i at [DATA_WIDTH*i +: DATA_WIDTH]
//   err_flg_o      sticky errors: [0] sample dropped, [1] unexpected read
// ---------------------------------------------------------------------------
module fir_ram_data_buf #(
    parameter int FILTER_ORDER = 256,
    parameter int DATA_WIDTH   = 16,
    parameter int PARALLEL     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic signed [DATA_WIDTH-1:0]   sample_i,
    input  logic                           sample_val_i,
    output logic                           sample_rdy_o,
    output logic                           data_val_o,
    input  logic                           data_ram_rd_i,
    output logic [DATA_WIDTH*PARALLEL-1:0] data_ram_o,
    output logic [1:0]                     err_flg_o
);

    localparam int ITERATION = FILTER_ORDER / PARALLEL;
    localparam int AW        = $clog2(FILTER_ORDER);
    localparam int LW        = $clog2(ITERATION);
    localparam int PW        = $clog2(PARALLEL);

    localparam logic [1:0] INIT_S  = 2'd0;
    localparam logic [1:0] IDLE_S  = 2'd1;
    localparam logic [1:0] START_S = 2'd2;
    localparam logic [1:0] SERVE_S = 2'd3;

`ifdef FIR_RAM_DBUF_CLEAR_EN
    localparam logic [1:0] RST_S = INIT_S;
`else
    localparam logic [1:0] RST_S = IDLE_S;
`endif

    logic [1:0]    state;
    logic [AW-1:0] wp;
    logic [AW-1:0] base;
    logic [LW-1:0] rd_cnt;
    logic [1:0]    err;

    logic          sample_we;
    logic          rd_acc_p0;
    logic [AW-1:0] rd_addr_p0;
    logic [PW-1:0] wp_bank;
    logic [LW-1:0] wp_addr;

    logic                         vld_p1;
    logic [PW-1:0]                sel_p1;
    logic signed [DATA_WIDTH-1:0] bank_rd_p1 [PARALLEL];
    logic [PW-1:0]                lane_sel   [PARALLEL];

`ifdef FIR_RAM_DBUF_CLEAR_EN
    logic [LW-1:0] init_cnt;
    logic          init_we;
    assign init_we = (state == INIT_S) && rst_n_i;
`endif

    assign sample_rdy_o = (state == IDLE_S);
    assign data_val_o   = (state == START_S);
    assign err_flg_o    = err;

    // Banks are never written while reset is asserted so a reset leaves the
    // stored history untouched (apart from the optional zero-fill).
    assign sample_we  = (state == IDLE_S) && sample_val_i && rst_n_i;
    assign rd_acc_p0  = (state == SERVE_S) && data_ram_rd_i && rst_n_i;
    assign wp_bank    = wp[AW-1:LW];
    assign wp_addr    = wp[LW-1:0];
    // Step k addresses the sample k positions older than the newest one;
    // lanes then fan out ITERATION positions apart, i.e. one bank apart.
    assign rd_addr_p0 = base - {{(AW-LW){1'b0}}, rd_cnt};

    // Control FSM, write pointer and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= RST_S;
            wp     <= '0;
            base   <= '0;
            rd_cnt <= '0;
            err    <= '0;
`ifdef FIR_RAM_DBUF_CLEAR_EN
            init_cnt <= '0;
`endif
        end else begin
            if (sample_val_i && (state != IDLE_S))
                err[0] <= 1'b1;
            if (data_ram_rd_i && (state != SERVE_S))
                err[1] <= 1'b1;
            case (state)
                INIT_S: begin
`ifdef FIR_RAM_DBUF_CLEAR_EN
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LW'(ITERATION - 1))
                        state <= IDLE_S;
`else
                    state <= IDLE_S;
`endif
                end
                IDLE_S: begin
                    if (sample_val_i) begin
                        base  <= wp;
                        wp    <= wp + 1'b1;
                        state <= START_S;
                    end
                end
                START_S: begin
                    rd_cnt <= '0;
                    state  <= SERVE_S;
                end
                SERVE_S: begin
                    if (data_ram_rd_i) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LW'(ITERATION - 1))
                            state <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

    // ---- stage p0 -> p1: bank read, all banks at the same address ----
    for (genvar b = 0; b < PARALLEL; b++) begin : g_bank
        logic signed [DATA_WIDTH-1:0] mem [ITERATION];
        logic signed [DATA_WIDTH-1:0] rd_p1;

        always_ff @(posedge clk_i) begin
`ifdef FIR_RAM_DBUF_CLEAR_EN
            if (init_we)
                mem[init_cnt] <= '0;
            else if (sample_we && (wp_bank == PW'(b)))
                mem[wp_addr] <= sample_i;
`else
            if (sample_we && (wp_bank == PW'(b)))
                mem[wp_addr] <= sample_i;
`endif
            if (rd_acc_p0)
                rd_p1 <= mem[rd_addr_p0[LW-1:0]];
        end

        assign bank_rd_p1[b] = rd_p1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= rd_acc_p0;
    end

    always_ff @(posedge clk_i) begin
        if (rd_acc_p0)
            sel_p1 <= rd_addr_p0[AW-1:LW];
    end

    // ---- stage p1 -> p2: rotating crossbar, lane i takes bank (sel - i) ----
    for (genvar i = 0; i < PARALLEL; i++) begin : g_sel
        assign lane_sel[i] = sel_p1 - PW'(i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_ram_o <= '0;
        end else if (vld_p1) begin
            for (int i = 0; i < PARALLEL; i++)
                data_ram_o[DATA_WIDTH*i +: DATA_WIDTH] <= bank_rd_p1[lane_sel[i]];
        end
    end

endmodule

// File: tb/tb_fir_ram_data_buf.sv
module tb_fir_ram_data_buf;

    localparam int FO  = 16;
    localparam int DW  = 16;
    localparam int PAR = 4;

    logic                  clk = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic signed [DW-1:0]  sample_i = '0;
    logic                  sample_val_i = 1'b0;
    logic                  sample_rdy_o;
    logic                  data_val_o;
    logic                  data_ram_rd_i = 1'b0;
    logic [DW*PAR-1:0]     data_ram_o;
    logic [1:0]            err_flg_o;

    fir_ram_data_buf #(
        .FILTER_ORDER (FO),
        .DATA_WIDTH   (DW),
        .PARALLEL     (PAR)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .sample_i      (sample_i),
        .sample_val_i  (sample_val_i),
        .sample_rdy_o  (sample_rdy_o),
        .data_val_o    (data_val_o),
        .data_ram_rd_i (data_ram_rd_i),
        .data_ram_o    (data_ram_o),
        .err_flg_o     (err_flg_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] exp_q [$];
    logic [63:0] last_exp = '0;
    logic        rd_exp = 1'b0;
    logic [1:0]  pipe = 2'b00;
    int          hist [16];

    // lane 0 first, matching the {lane0,lane1,lane2,lane3} notation
    function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
    endfunction

    // expected step-k vector from the history model: lane i = x[n-(4i+k)]
    function automatic logic [63:0] model_step(input int k);
        return pk(hist[k], hist[4+k], hist[8+k], hist[12+k]);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: an expected vector becomes due 2 cycles after its strobe.
    always @(posedge clk) pipe <= {pipe[0], rd_exp};

    always @(negedge clk) begin
        if (pipe[1]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_vec: got %h, expected nothing queued", data_ram_o);
            end else begin
                check("rd_vec", data_ram_o, exp_q.pop_front());
            end
        end
    end

    task automatic rd_one(input logic [63:0] e, input bit chk);
        data_ram_rd_i = 1'b1;
        rd_exp        = chk;
        if (chk) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        @(negedge clk);
        data_ram_rd_i = 1'b0;
        rd_exp        = 1'b0;
    endtask

    task automatic burst_model(input bit chk);
        for (int k = 0; k < 4; k++)
            rd_one(model_step(k), chk);
    endtask

    task automatic burst_hand(input logic [63:0] v0, input logic [63:0] v1,
                              input logic [63:0] v2, input logic [63:0] v3);
        rd_one(v0, 1'b1);
        rd_one(v1, 1'b1);
        rd_one(v2, 1'b1);
        rd_one(v3, 1'b1);
    endtask

    // Offer one sample; returns at the negedge of the first SERVE cycle.
    task automatic send(input int v);
        int guard;
        guard = 0;
        while (!sample_rdy_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rdy_timeout: sample_rdy_o stayed 0, required 1");
        end
        sample_i     = DW'(v);
        sample_val_i = 1'b1;
        @(negedge clk);
        sample_val_i = 1'b0;
        check("data_val_pulse", data_val_o, 1);
        check("rdy_low_after_accept", sample_rdy_o, 0);
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    // One-cycle reset, checks of reset values, then wait until ready.
    task automatic do_reset();
        rst_n_i       = 1'b0;
        sample_val_i  = 1'b0;
        data_ram_rd_i = 1'b0;
        rd_exp        = 1'b0;
        @(negedge clk);
        check("rst_data_val", data_val_o, 0);
        check("rst_data_ram", data_ram_o, 0);
        check("rst_err", err_flg_o, 0);
        for (int i = 0; i < 16; i++) hist[i] = 0;
`ifdef FIR_RAM_DBUF_CLEAR_EN
        check("rst_rdy", sample_rdy_o, 0);
        rst_n_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("init_rdy_low", sample_rdy_o, 0);
        end
        @(negedge clk);
        check("init_rdy_high", sample_rdy_o, 1);
`else
        check("rst_rdy", sample_rdy_o, 1);
        rst_n_i = 1'b1;
        @(negedge clk);
        // no zero-fill in this build: establish a zero history explicitly
        for (int s = 0; s < 16; s++) begin
            send(0);
            burst_model(1'b0);
        end
        drain();
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) hist[i] = 0;
        @(negedge clk);

        // Scenario 1: reset, first sample over a zero history
        do_reset();
        send(7);
        burst_hand(pk(7,0,0,0), pk(0,0,0,0), pk(0,0,0,0), pk(0,0,0,0));
        drain();

        // Scenario 2: samples 1..5
        do_reset();
        for (int v = 1; v <= 4; v++) begin
            send(v);
            burst_model(1'b1);
        end
        send(5);
        burst_hand(pk(5,1,0,0), pk(4,0,0,0), pk(3,0,0,0), pk(2,0,0,0));

        // Scenario 3: continue to 20 samples, write pointer wraps
        for (int v = 6; v <= 19; v++) begin
            send(v);
            burst_model(1'b1);
        end
        send(20);
        burst_hand(pk(20,16,12,8), pk(19,15,11,7), pk(18,14,10,6), pk(17,13,9,5));
        drain();

        // Scenario 4: sample offered during SERVE_S is dropped
        send(30);
        rd_one(model_step(0), 1'b1);
        sample_i     = 16'sd99;
        sample_val_i = 1'b1;
        @(negedge clk);
        sample_val_i = 1'b0;
        check("drop_err", err_flg_o, 2'b01);
        check("drop_rdy", sample_rdy_o, 0);
        for (int k = 1; k < 4; k++) rd_one(model_step(k), 1'b1);
        send(31);
        burst_hand(pk(31,18,14,10), pk(30,17,13,9), pk(20,16,12,8), pk(19,15,11,7));
        drain();
        check("drop_err_hold", err_flg_o, 2'b01);

        // Scenario 5: read strobe while idle
        data_ram_rd_i = 1'b1;
        @(negedge clk);
        data_ram_rd_i = 1'b0;
        check("idle_rd_err", err_flg_o, 2'b11);
        check("idle_rd_rdy", sample_rdy_o, 1);
        repeat (3) @(negedge clk);
        check("idle_rd_hold", data_ram_o, last_exp);
        check("idle_rd_noval", data_val_o, 0);
        check("idle_rd_rdy2", sample_rdy_o, 1);

        // Scenario 6: reset after the 2nd read of a burst
        send(40);
        rd_one(model_step(0), 1'b1);
        rd_one(model_step(1), 1'b0);
        do_reset();
        send(9);
        burst_hand(pk(9,0,0,0), pk(0,0,0,0), pk(0,0,0,0), pk(0,0,0,0));
        drain();
        check("final_err", err_flg_o, 2'b00);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_empty: %0d vectors left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
